// File: rtl/commit_rename_freelist_if.sv
// Commit, allocation and committed-RAT lookup bundle for commit_rename_freelist.
// The design drives OUT_* through the slave modport; ROB/rename drive IN_* through master.
interface commit_rename_freelist_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0]   IN_comValid;
    logic [WIDTH*5-1:0] IN_comNames;
    logic [WIDTH*6-1:0] IN_comTags;
    logic [WIDTH-1:0]   IN_allocReq;
    logic [WIDTH-1:0]   OUT_allocValid;
    logic [WIDTH*6-1:0] OUT_allocTags;
    logic               IN_flush;
    logic [4:0]         IN_rdName;
    logic [5:0]         OUT_rdTag;
    logic [6:0]         OUT_freeCount;

    modport master (
        output IN_comValid, IN_comNames, IN_comTags, IN_allocReq, IN_flush, IN_rdName,
        input  OUT_allocValid, OUT_allocTags, OUT_rdTag, OUT_freeCount
    );

    modport slave (
        input  IN_comValid, IN_comNames, IN_comTags, IN_allocReq, IN_flush, IN_rdName,
        output OUT_allocValid, OUT_allocTags, OUT_rdTag, OUT_freeCount
    );
endinterface

// File: rtl/commit_rename_freelist.sv
// Committed RAT plus circular physical-tag free list with speculative allocation and flush rewind.
// Optional macro RAT_RD_BYPASS_EN forwards same-cycle commits onto OUT_rdTag.
module commit_rename_freelist #(
    parameter int WIDTH    = 2,
    parameter int NUM_TAGS = 64,
    parameter int NUM_REGS = 32
) (
    input logic clk,
    input logic rst,
    commit_rename_freelist_if.slave bus
);
    localparam int TAG_W     = $clog2(NUM_TAGS);
    localparam int NAME_W    = $clog2(NUM_REGS);
    localparam int PTR_W     = TAG_W + 1;
    localparam int INIT_FREE = NUM_TAGS - NUM_REGS;

    logic [TAG_W-1:0]  rat_com [NUM_REGS];
    logic [TAG_W-1:0]  fl [NUM_TAGS];
    logic [PTR_W-1:0]  wr_ptr, spec_rd_ptr, com_rd_ptr;
    logic [PTR_W-1:0]  free_count, grants, com_cnt;
    logic [TAG_W-1:0]  rd_idx;
    logic              blocked;

    logic [WIDTH-1:0]  com_eff;
    logic [NAME_W-1:0] com_name [WIDTH];
    logic [TAG_W-1:0]  com_tag  [WIDTH];
    logic [TAG_W-1:0]  old_tag  [WIDTH];
    logic [TAG_W-1:0]  push_idx [WIDTH];

    assign free_count        = wr_ptr - spec_rd_ptr;
    assign bus.OUT_freeCount = free_count;

    // Lower slots forward their new mapping so a repeated name frees the lower slot's tag.
    always_comb begin
        com_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            com_name[i] = bus.IN_comNames[i*NAME_W +: NAME_W];
            com_tag[i]  = bus.IN_comTags[i*TAG_W +: TAG_W];
            com_eff[i]  = bus.IN_comValid[i] && (com_name[i] != '0);
            old_tag[i]  = rat_com[com_name[i]];
            for (int unsigned j = 0; j < i; j++) begin
                if (com_eff[j] && (com_name[j] == com_name[i]))
                    old_tag[i] = com_tag[j];
            end
            push_idx[i] = TAG_W'(wr_ptr + com_cnt);
            if (com_eff[i])
                com_cnt = com_cnt + PTR_W'(1);
        end
    end

    always_comb begin
        grants             = '0;
        blocked            = 1'b0;
        rd_idx             = '0;
        bus.OUT_allocValid = '0;
        bus.OUT_allocTags  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus.IN_allocReq[i] && !blocked) begin
                if (!bus.IN_flush && (grants < free_count)) begin
                    rd_idx                              = TAG_W'(spec_rd_ptr + grants);
                    bus.OUT_allocValid[i]               = 1'b1;
                    bus.OUT_allocTags[i*TAG_W +: TAG_W] = fl[rd_idx];
                    grants                              = grants + PTR_W'(1);
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.OUT_rdTag = rat_com[bus.IN_rdName];
`ifdef RAT_RD_BYPASS_EN
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (com_eff[i] && (com_name[i] == bus.IN_rdName))
                bus.OUT_rdTag = com_tag[i];
        end
`endif
        if (bus.IN_rdName == '0)
            bus.OUT_rdTag = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                rat_com[r] <= TAG_W'(r);
            for (int unsigned i = 0; i < NUM_TAGS; i++)
                fl[i] <= (i < INIT_FREE) ? TAG_W'(NUM_REGS + i) : '0;
            wr_ptr      <= PTR_W'(INIT_FREE);
            spec_rd_ptr <= '0;
            com_rd_ptr  <= '0;
        end else begin
            // Later slots come later in the loop, so a repeated name keeps the highest slot's tag.
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (com_eff[i]) begin
                    fl[push_idx[i]]      <= old_tag[i];
                    rat_com[com_name[i]] <= com_tag[i];
                end
            end
            wr_ptr      <= wr_ptr + com_cnt;
            com_rd_ptr  <= com_rd_ptr + com_cnt;
            spec_rd_ptr <= bus.IN_flush ? (com_rd_ptr + com_cnt) : (spec_rd_ptr + grants);
        end
    end
endmodule

// File: tb/tb_commit_rename_freelist.sv
// Self-checking bench for commit_rename_freelist: directed table, hand sequences, random vs model.
// Build with RAT_RD_BYPASS_EN defined to check the forwarding lookup variant.
`timescale 1ns/1ps
module tb_commit_rename_freelist;
`ifdef RAT_RD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    commit_rename_freelist_if #(.WIDTH(2)) bus ();
    commit_rename_freelist #(.WIDTH(2), .NUM_TAGS(64), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int passed = 0;
    int total  = 0;

    // Reference: free list as an unbounded history of absolute positions plus plain RAT array.
    int hist [int];
    int m_wr, m_spec, m_com;
    int m_rat [32];

    logic [1:0] e_valid, a_valid;
    int e_tag [2];
    int a_tag [2];
    int e_fc, a_fc, e_rd, a_rd;
    int inflight [$];

    typedef struct {
        logic [1:0] req;
        logic [1:0] cv;
        int n0, t0, n1, t1;
        logic fl;
        int rd;
        logic [1:0] ev;
        int et0, et1, efc, erd, erd_byp;
    } vec_t;

    vec_t vecs [6];
    int freed [4] = '{5, 7, 3, 40};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.IN_allocReq = '0; bus.IN_comValid = '0; bus.IN_comNames = '0;
        bus.IN_comTags = '0; bus.IN_flush = 1'b0; bus.IN_rdName = '0;
    endtask

    // Activity during reset must be ignored.
    task automatic do_reset();
        rst = 1'b1;
        bus.IN_allocReq = 2'b11; bus.IN_comValid = 2'b11;
        bus.IN_comNames = {5'd4, 5'd6}; bus.IN_comTags = {6'd50, 6'd51};
        bus.IN_flush = 1'b1; bus.IN_rdName = 5'd4;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        hist.delete();
        for (int i = 0; i < 32; i++) hist[i] = 32 + i;
        for (int r = 0; r < 32; r++) m_rat[r] = r;
        m_wr = 32; m_spec = 0; m_com = 0;
        #1;
        check("reset_free_count", int'(bus.OUT_freeCount), 32);
    endtask

    task automatic step(input logic [1:0] req, input logic [1:0] cv, input int n0, input int t0,
                        input int n1, input int t1, input logic flush, input int rd);
        int names [2];
        int tags [2];
        int g;
        bit blk;
        names = '{n0, n1};
        tags  = '{t0, t1};
        bus.IN_allocReq = req; bus.IN_comValid = cv;
        bus.IN_comNames = {5'(n1), 5'(n0)}; bus.IN_comTags = {6'(t1), 6'(t0)};
        bus.IN_flush = flush; bus.IN_rdName = 5'(rd);
        #1;
        e_fc = m_wr - m_spec;
        e_valid = '0; e_tag = '{0, 0}; g = 0; blk = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (req[i] && !blk) begin
                if (!flush && g < e_fc) begin
                    e_valid[i] = 1'b1; e_tag[i] = hist[m_spec + g]; g++;
                end else blk = 1'b1;
            end
        end
        e_rd = (rd == 0) ? 0 : m_rat[rd];
        if (BYPASS)
            for (int i = 0; i < 2; i++)
                if (cv[i] && names[i] != 0 && names[i] == rd && rd != 0) e_rd = tags[i];
        a_valid  = bus.OUT_allocValid;
        a_tag[0] = int'(bus.OUT_allocTags[5:0]);
        a_tag[1] = int'(bus.OUT_allocTags[11:6]);
        a_fc     = int'(bus.OUT_freeCount);
        a_rd     = int'(bus.OUT_rdTag);
        check("model_alloc_valid", int'(a_valid), int'(e_valid));
        check("model_alloc_tag0", a_tag[0], e_tag[0]);
        check("model_alloc_tag1", a_tag[1], e_tag[1]);
        check("model_free_count", a_fc, e_fc);
        check("model_rd_tag", a_rd, e_rd);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (cv[i] && names[i] != 0) begin
                hist[m_wr] = m_rat[names[i]];
                m_wr++;
                m_rat[names[i]] = tags[i];
                m_com++;
            end
        end
        m_spec = flush ? m_com : m_spec + g;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();

        vecs[0] = '{2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 5, 2'b11, 32, 33, 32, 5, 5};
        vecs[1] = '{2'b00, 2'b11, 5, 32, 7, 33, 1'b0, 5, 2'b00, 0, 0, 30, 5, 32};
        vecs[2] = '{2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 7, 2'b00, 0, 0, 32, 33, 33};
        vecs[3] = '{2'b00, 2'b11, 3, 40, 3, 41, 1'b0, 3, 2'b00, 0, 0, 32, 3, 41};
        vecs[4] = '{2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 3, 2'b00, 0, 0, 34, 41, 41};
        vecs[5] = '{2'b10, 2'b00, 0, 0, 0, 0, 1'b0, 0, 2'b10, 0, 34, 34, 0, 0};
        for (int v = 0; v < 6; v++) begin
            step(vecs[v].req, vecs[v].cv, vecs[v].n0, vecs[v].t0, vecs[v].n1, vecs[v].t1,
                 vecs[v].fl, vecs[v].rd);
            check($sformatf("vec%0d_valid", v), int'(a_valid), int'(vecs[v].ev));
            check($sformatf("vec%0d_tag0", v), a_tag[0], vecs[v].et0);
            check($sformatf("vec%0d_tag1", v), a_tag[1], vecs[v].et1);
            check($sformatf("vec%0d_free_count", v), a_fc, vecs[v].efc);
            check($sformatf("vec%0d_rd_tag", v), a_rd, BYPASS ? vecs[v].erd_byp : vecs[v].erd);
        end

        // Drain: positions 3..35; the last four are the freed tags in commit order.
        for (int k = 0; k < 33; k++) begin
            step(2'b01, 2'b00, 0, 0, 0, 0, 1'b0, 0);
            check("drain_tag", a_tag[0], (3 + k < 32) ? 35 + k : freed[3 + k - 32]);
        end
        step(2'b01, 2'b01, 9, 50, 0, 0, 1'b0, 9);
        check("empty_no_grant", int'(a_valid), 0);
        check("empty_free_count", a_fc, 0);
        check("bypass_rd_same_cycle", a_rd, BYPASS ? 50 : 9);
        step(2'b01, 2'b00, 0, 0, 0, 0, 1'b0, 9);
        check("refill_valid", int'(a_valid), 1);
        check("refill_tag", a_tag[0], 9);
        check("refill_free_count", a_fc, 1);
        check("rd_next_cycle", a_rd, 50);

        // Flush rewinds speculative allocation to the committed point.
        do_reset();
        for (int k = 0; k < 3; k++) step(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        step(2'b00, 2'b11, 1, 32, 2, 33, 1'b0, 1);
        step(2'b11, 2'b00, 0, 0, 0, 0, 1'b1, 0);
        check("flush_no_grant", int'(a_valid), 0);
        check("flush_cycle_free_count", a_fc, 28);
        step(2'b11, 2'b01, 4, 34, 0, 0, 1'b1, 0);
        check("after_flush_free_count", a_fc, 32);
        check("flush_commit_no_grant", int'(a_valid), 0);
        step(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 4);
        check("flush_commit_free_count", a_fc, 32);
        check("flush_commit_rat", a_rd, 34);
        for (int k = 0; k < 13; k++) step(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        step(2'b01, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        step(2'b10, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        check("req10_free_count", a_fc, 5);
        check("req10_valid", int'(a_valid), 2);
        check("req10_tag0", a_tag[0], 0);
        check("req10_tag1", a_tag[1], 62);

        // Random ROB-like traffic: commits retire previously granted tags in order.
        do_reset();
        inflight.delete();
        for (int c = 0; c < 400; c++) begin
            logic [1:0] cv;
            int nm [2];
            int tg [2];
            logic fl;
            cv = '0; nm = '{0, 0}; tg = '{0, 0};
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 1) == 1 && inflight.size() > 0) begin
                    cv[i] = 1'b1;
                    nm[i] = $urandom_range(1, 31);
                    tg[i] = inflight.pop_front();
                end else if ($urandom_range(0, 3) == 0) begin
                    cv[i] = 1'b1;
                    tg[i] = $urandom_range(0, 63);
                end
            end
            fl = ($urandom_range(0, 19) == 0);
            step(2'($urandom), cv, nm[0], tg[0], nm[1], tg[1], fl, $urandom_range(0, 31));
            for (int i = 0; i < 2; i++) if (e_valid[i]) inflight.push_back(e_tag[i]);
            if (fl) inflight.delete();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
